// File: rtl/sng_bitstream.sv
// Stochastic number generator: turns a binary probability into a unipolar bitstream of req_len bits.
// Optional SNG_ONES_COUNT_EN enables the accepted-ones counter; otherwise ones_cnt is tied to 0.
module sng_bitstream #(
  parameter int unsigned RND_W = 32,
  parameter int unsigned PW    = 8,
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RND_W-1:0] rnd,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [PW-1:0]    req_prob,
  input  logic [LEN_W-1:0] req_len,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             bit_last,
  output logic             done,
  output logic [LEN_W-1:0] ones_cnt
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    prob_q, prob_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             bit_q, bit_d;
  logic [PW-1:0]    prob_sel;
  logic             new_bit;
  logic             unused_rnd;

  // The first bit is generated in the handshake cycle, before prob_q holds the new value.
  assign prob_sel   = (state_q == StIdle) ? req_prob : prob_q;
  assign new_bit    = (rnd[RND_W-1 -: PW] < prob_sel);
  assign unused_rnd = ^rnd[RND_W-PW-1:0];

  always_comb begin
    state_d = state_q;
    prob_d  = prob_q;
    rem_d   = rem_q;
    bit_d   = bit_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          prob_d = req_prob;
          rem_d  = req_len;
          if (req_len != '0) begin
            state_d = StRun;
            bit_d   = new_bit;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (bit_ready) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = StDone;
            bit_d   = 1'b0;
          end else begin
            bit_d = new_bit;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        bit_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      prob_q  <= '0;
      rem_q   <= '0;
      bit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prob_q  <= prob_d;
      rem_q   <= rem_d;
      bit_q   <= bit_d;
    end
  end

`ifdef SNG_ONES_COUNT_EN
  logic [LEN_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle && req_valid) begin
      cnt_d = '0;
    end else if (state_q == StRun && bit_ready) begin
      cnt_d = cnt_q + LEN_W'(bit_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ones_cnt = cnt_q;
`else
  assign ones_cnt = '0;
`endif

  assign req_ready = (state_q == StIdle);
  assign bit_valid = (state_q == StRun);
  assign bit_last  = bit_valid && (rem_q == LEN_W'(1));
  assign bit_out   = bit_q;
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_sng_bitstream.sv
// Self-checking bench for sng_bitstream: stream-level reference model, random rnd/backpressure,
// plus a Tausworthe-88 source for the statistical check.
module tb_sng_bitstream;

`ifdef SNG_ONES_COUNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rnd;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_prob;
  logic [15:0] req_len;
  logic        bit_out;
  logic        bit_valid;
  logic        bit_ready;
  logic        bit_last;
  logic        done;
  logic [15:0] ones_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] s1, s2, s3;

  sng_bitstream #(.RND_W(32), .PW(8), .LEN_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .rnd       (rnd),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_prob  (req_prob),
    .req_len   (req_len),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .bit_last  (bit_last),
    .done      (done),
    .ones_cnt  (ones_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] exp_cnt(input int ones);
    return CntEn ? ones[15:0] : 16'd0;
  endfunction

  task automatic taus_seed(input logic [31:0] seed);
    s1 = seed;
    s2 = ~seed;
    s3 = seed ^ 32'h5A5A_5A5A;
  endtask

  task automatic taus_next(output logic [31:0] r);
    logic [31:0] b;
    b  = ((s1 << 13) ^ s1) >> 19;
    s1 = ((s1 & 32'hFFFF_FFFE) << 12) ^ b;
    b  = ((s2 << 2) ^ s2) >> 25;
    s2 = ((s2 & 32'hFFFF_FFF8) << 4) ^ b;
    b  = ((s3 << 3) ^ s3) >> 11;
    s3 = ((s3 & 32'hFFFF_FFF0) << 17) ^ b;
    r  = s1 ^ s2 ^ s3;
  endtask

  // rmode: 0 constant 8000_0000, 1 $urandom, 2 Tausworthe-88
  task automatic get_rnd(input int rmode, output logic [31:0] r);
    if (rmode == 0) r = 32'h8000_0000;
    else if (rmode == 1) r = $urandom;
    else taus_next(r);
  endtask

  // Runs one job starting at a negedge in IDLE; returns with the block back in IDLE at a negedge.
  // br_mode: 0 always ready, 1 random ready, 2 five stall cycles on the second bit.
  task automatic job(input logic [7:0] prob, input int len, input int br_mode, input int rmode,
                     output int tally);
    logic [31:0] r;
    logic        exp_bit;
    logic        obs;
    bit          br;
    int          ones;
    int          stall;
    ones  = 0;
    tally = 0;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL job_req_ready: got %b exp 1", req_ready);
    end
    req_valid = 1'b1;
    req_prob  = prob;
    req_len   = len[15:0];
    get_rnd(rmode, r);
    rnd     = r;
    exp_bit = (r[31:24] < prob);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      stall = 0;
      do begin
        checks += 6;
        if (bit_valid !== 1'b1) begin
          errors++; $display("FAIL bit_valid bit %0d: got %b exp 1", i, bit_valid);
        end
        if (bit_out !== exp_bit) begin
          errors++; $display("FAIL bit_out bit %0d: got %b exp %b", i, bit_out, exp_bit);
        end
        if (bit_last !== (i == len - 1)) begin
          errors++; $display("FAIL bit_last bit %0d: got %b exp %b", i, bit_last, i == len - 1);
        end
        if (done !== 1'b0) begin
          errors++; $display("FAIL done_in_run bit %0d: got %b exp 0", i, done);
        end
        if (req_ready !== 1'b0) begin
          errors++; $display("FAIL req_ready_in_run bit %0d: got %b exp 0", i, req_ready);
        end
        if (ones_cnt !== exp_cnt(ones)) begin
          errors++; $display("FAIL ones_cnt_run bit %0d: got %0d exp %0d", i, ones_cnt,
                             exp_cnt(ones));
        end
        obs = bit_out;
        case (br_mode)
          0:       br = 1'b1;
          1:       br = ($urandom_range(0, 3) != 0);
          default: br = !(i == 1 && stall < 5);
        endcase
        if (stall >= 40) br = 1'b1;
        if (!br) stall++;
        bit_ready = br;
        // Requests during RUN must be ignored.
        req_valid = 1'($urandom_range(0, 1));
        req_prob  = 8'($urandom);
        req_len   = 16'($urandom);
        get_rnd(rmode, r);
        rnd = r;
        @(negedge clk);
      end while (!br);
      ones  += int'(exp_bit);
      tally += int'(obs);
      exp_bit = (r[31:24] < prob);
    end
    bit_ready = 1'($urandom_range(0, 1));
    checks += 4;
    if (done !== 1'b1) begin
      errors++; $display("FAIL done_pulse: got %b exp 1", done);
    end
    if (bit_valid !== 1'b0) begin
      errors++; $display("FAIL bit_valid_done: got %b exp 0", bit_valid);
    end
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL req_ready_done: got %b exp 0", req_ready);
    end
    if (ones_cnt !== exp_cnt(ones)) begin
      errors++; $display("FAIL ones_cnt_done: got %0d exp %0d", ones_cnt, exp_cnt(ones));
    end
    @(negedge clk);
    req_valid = 1'b0;
    bit_ready = 1'b0;
    checks += 4;
    if (done !== 1'b0) begin
      errors++; $display("FAIL done_width: got %b exp 0", done);
    end
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL req_ready_after: got %b exp 1", req_ready);
    end
    if (bit_valid !== 1'b0) begin
      errors++; $display("FAIL bit_valid_after: got %b exp 0", bit_valid);
    end
    if (ones_cnt !== exp_cnt(ones)) begin
      errors++; $display("FAIL ones_cnt_hold: got %0d exp %0d", ones_cnt, exp_cnt(ones));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks += 6;
    if (bit_out !== 1'b0) begin
      errors++; $display("FAIL %s bit_out: got %b exp 0", tag, bit_out);
    end
    if (bit_valid !== 1'b0) begin
      errors++; $display("FAIL %s bit_valid: got %b exp 0", tag, bit_valid);
    end
    if (bit_last !== 1'b0) begin
      errors++; $display("FAIL %s bit_last: got %b exp 0", tag, bit_last);
    end
    if (done !== 1'b0) begin
      errors++; $display("FAIL %s done: got %b exp 0", tag, done);
    end
    if (ones_cnt !== 16'd0) begin
      errors++; $display("FAIL %s ones_cnt: got %0d exp 0", tag, ones_cnt);
    end
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s req_ready: got %b exp 1", tag, req_ready);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    check_reset_outputs("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_released");
  endtask

  task automatic test_const_streams();
    int t;
    job(8'h80, 4, 0, 0, t);
    checks++;
    if (t !== 0) begin
      errors++; $display("FAIL const_zero_tally: got %0d exp 0", t);
    end
    job(8'h81, 4, 0, 0, t);
    checks++;
    if (t !== 4) begin
      errors++; $display("FAIL const_one_tally: got %0d exp 4", t);
    end
  endtask

  task automatic test_len_zero();
    int t;
    job(8'($urandom), 0, 0, 1, t);
  endtask

  task automatic test_stall();
    int t;
    job(8'h81, 3, 2, 1, t);
  endtask

  task automatic test_reset_mid_job();
    int t;
    req_valid = 1'b1;
    req_prob  = 8'h81;
    req_len   = 16'd10;
    rnd       = 32'h0000_0000;
    @(negedge clk);
    req_valid = 1'b0;
    bit_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_job_reset");
    @(negedge clk);
    rst       = 1'b0;
    bit_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_reset_outputs("post_reset_idle");
    end
    job(8'h81, 2, 0, 1, t);
  endtask

  task automatic test_random_back_to_back();
    int t;
    logic [7:0] p;
    for (int j = 0; j < 12; j++) begin
      if (j == 0) p = 8'h00;
      else if (j == 1) p = 8'hFF;
      else p = 8'($urandom);
      job(p, $urandom_range(1, 20), 1, 1, t);
      if (p == 8'h00) begin
        checks++;
        if (t !== 0) begin
          errors++; $display("FAIL prob_zero_tally: got %0d exp 0", t);
        end
      end
    end
  endtask

  task automatic test_taus();
    int t;
    int n;
    taus_seed(32'hDEAD_BEEF);
    job(8'h40, 4096, 1, 2, t);
    n = CntEn ? int'(ones_cnt) : t;
    checks++;
    if (n < 924 || n > 1124) begin
      errors++; $display("FAIL taus_ones_range: got %0d exp 924..1124", n);
    end
  endtask

  initial begin
    rst       = 1'b1;
    rnd       = '0;
    req_valid = 1'b0;
    req_prob  = '0;
    req_len   = '0;
    bit_ready = 1'b0;
    test_reset();
    test_const_streams();
    test_len_zero();
    test_stall();
    test_reset_mid_job();
    test_random_back_to_back();
    test_taus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
